posit_extract: RTL

- Pipelined posit field decoder that sits directly upstream of positmult in the Pair-HMM posit datapath.
- Unpacks a packed N-bit posit into sign, combined scale (regime*2^es + exponent) and a left-aligned mantissa with hidden bit, plus zero/NaR flags.
- Uses the same start/done pulse handshake as positmult, so operand decode is a separate registered stage ahead of the multiplier core.

---
 rtl/posit_extract.sv | 116 +++++++++++
 1 files changed

// File: rtl/posit_extract.sv
`default_nettype none
// ============================================================================
// Module   : posit_extract
// Function : Two-stage posit field decoder (sign, scale, hidden-bit mantissa,
//            zero/NaR flags) feeding the posit multiplier.
// Revision : 1.0 - initial release
// ============================================================================
module posit_extract #(
    parameter int N  = 32,
    parameter int ES = 2,
    parameter int SW = $clog2(N) + ES + 1,
    parameter int MW = N - ES - 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  in,
    input  logic          start,
    output logic          sign,
    output logic [SW-1:0] scale,
    output logic [MW-1:0] mant,
    output logic          zero,
    output logic          inf,
    output logic          done
);

    localparam int LW = $clog2(N) + 1;

    logic          r_s1_valid;
    logic          r_s1_sign;
    logic [N-1:0]  r_s1_abs;
    logic          r_s1_zero;
    logic          r_s1_inf;

    logic [N-1:0]  w_abs;
    logic [N-2:0]  w_body;
    logic          w_rbit;
    logic [N-2:0]  w_inv;
    logic [LW-1:0] w_m;
    logic [N-2:0]  w_sh;
    logic [ES-1:0] w_e;
    logic [SW-1:0] w_k;
    logic [SW-1:0] w_scale;
    logic [MW-1:0] w_mant;

    assign w_abs = in[N-1] ? (~in + 1'b1) : in;

    // Data registers load only with start so idle-cycle garbage on in never
    // reaches stage 2.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_abs   <= '0;
            r_s1_zero  <= 1'b0;
            r_s1_inf   <= 1'b0;
        end else begin
            r_s1_valid <= start;
            if (start) begin
                r_s1_sign <= in[N-1];
                r_s1_abs  <= w_abs;
                r_s1_zero <= (in == '0);
                r_s1_inf  <= (in == {1'b1, {(N-1){1'b0}}});
            end
        end
    end

    assign w_body = r_s1_abs[N-2:0];
    assign w_rbit = w_body[N-2];
    assign w_inv  = w_rbit ? ~w_body : w_body;

    // Regime length: leading zeros of the run-normalised body; an all-run
    // body has no terminator and length N-1.
    always_comb begin
        w_m = LW'(N - 1);
        for (int i = 0; i < N - 1; i++) begin
            if (w_inv[i]) begin
                w_m = LW'(N - 2 - i);
            end
        end
    end

    // Drop the regime run plus its terminator; bits past the LSB shift in as 0.
    assign w_sh    = w_body << (w_m + LW'(1));
    assign w_e     = w_sh[N-2 -: ES];
    assign w_k     = w_rbit ? (SW'(w_m) - SW'(1)) : (SW'(0) - SW'(w_m));
    assign w_scale = {w_k[SW-1-ES:0], w_e};
    assign w_mant  = {1'b1, w_sh[N-2-ES -: MW-1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done  <= 1'b0;
            sign  <= 1'b0;
            scale <= '0;
            mant  <= '0;
            zero  <= 1'b0;
            inf   <= 1'b0;
        end else begin
            done <= r_s1_valid;
            if (r_s1_valid) begin
                zero <= r_s1_zero;
                inf  <= r_s1_inf;
                if (r_s1_zero || r_s1_inf) begin
                    sign  <= r_s1_inf;
                    scale <= '0;
                    mant  <= '0;
                end else begin
                    sign  <= r_s1_sign;
                    scale <= w_scale;
                    mant  <= w_mant;
                end
            end
        end
    end

endmodule
`default_nettype wire
